// File: rtl/hpdcache_mshr_sched_if.sv
// Bus bundle for the MSHR scheduler: the miss request channel, the refill ack
// channel, the MSHR command/status lines and the status outputs.
// slave  = the scheduler itself, master = the surrounding environment.
interface hpdcache_mshr_sched_if #(
    parameter int SET_W  = 7,
    parameter int TAG_W  = 20,
    parameter int MSET_W = 2,
    parameter int MWAY_W = 2,
    parameter int CNT_W  = 5
);
    logic              miss_valid_i;
    logic              miss_ready_o;
    logic [SET_W-1:0]  miss_set_i;
    logic [TAG_W-1:0]  miss_tag_i;
    logic              miss_rsp_valid_o;
    logic [1:0]        miss_rsp_o;
    logic              refill_valid_i;
    logic              refill_ready_o;
    logic [MSET_W-1:0] refill_set_i;
    logic [MWAY_W-1:0] refill_way_i;
    logic              refill_rsp_valid_o;
    logic              mshr_check_o;
    logic [SET_W-1:0]  mshr_check_set_o;
    logic [TAG_W-1:0]  mshr_check_tag_o;
    logic              mshr_hit_i;
    logic              mshr_alloc_full_i;
    logic              mshr_alloc_o;
    logic              mshr_alloc_cs_o;
    logic              mshr_ack_o;
    logic              mshr_ack_cs_o;
    logic [MSET_W-1:0] mshr_ack_set_o;
    logic [MWAY_W-1:0] mshr_ack_way_o;
    logic [CNT_W-1:0]  outstanding_o;
    logic              idle_o;
    logic              err_o;

    modport slave (
        input  miss_valid_i, miss_set_i, miss_tag_i,
        input  refill_valid_i, refill_set_i, refill_way_i,
        input  mshr_hit_i, mshr_alloc_full_i,
        output miss_ready_o, miss_rsp_valid_o, miss_rsp_o,
        output refill_ready_o, refill_rsp_valid_o,
        output mshr_check_o, mshr_check_set_o, mshr_check_tag_o,
        output mshr_alloc_o, mshr_alloc_cs_o,
        output mshr_ack_o, mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o,
        output outstanding_o, idle_o, err_o
    );

    modport master (
        output miss_valid_i, miss_set_i, miss_tag_i,
        output refill_valid_i, refill_set_i, refill_way_i,
        output mshr_hit_i, mshr_alloc_full_i,
        input  miss_ready_o, miss_rsp_valid_o, miss_rsp_o,
        input  refill_ready_o, refill_rsp_valid_o,
        input  mshr_check_o, mshr_check_set_o, mshr_check_tag_o,
        input  mshr_alloc_o, mshr_alloc_cs_o,
        input  mshr_ack_o, mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o,
        input  outstanding_o, idle_o, err_o
    );
endinterface

// File: rtl/hpdcache_mshr_sched.sv
// MSHR command scheduler: arbitrates refill acks against miss checks so the
// MSHR sees at most one command per cycle. A miss check takes two cycles
// (IDLE grant, CHK outcome); acks can issue every cycle. An ack burst limit
// keeps a waiting miss from starving behind continuous refills.
// Optional statistics counters: define HPDCACHE_MSHR_SCHED_STATS_EN.
module hpdcache_mshr_sched #(
    parameter int SET_W         = 7,
    parameter int TAG_W         = 20,
    parameter int MSET_W        = 2,
    parameter int MWAY_W        = 2,
    parameter int CNT_W         = 5,
    parameter int ACK_BURST_MAX = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    hpdcache_mshr_sched_if.slave     bus
`ifdef HPDCACHE_MSHR_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_alloc_o,
    output logic [31:0]              stat_hit_o,
    output logic [31:0]              stat_full_o
`endif
);
    localparam int BW = $clog2(ACK_BURST_MAX + 1);

    typedef enum logic {IDLE = 1'b0, CHK = 1'b1} state_t;

    state_t            r_state, w_state_next;
    logic [BW-1:0]     r_ack_burst;
    logic [SET_W-1:0]  r_set;
    logic [TAG_W-1:0]  r_tag;
    logic [CNT_W-1:0]  r_outstanding;
    logic              r_refill_rsp_valid;
    logic              r_err;
    logic              w_miss_wins;
    logic              w_refill_grant;
    logic              w_miss_grant;
    logic              w_alloc;

    // The ack target always follows the refill channel; only the strobes are gated.
    assign bus.mshr_ack_set_o     = bus.refill_set_i;
    assign bus.mshr_ack_way_o     = bus.refill_way_i;
    assign bus.refill_rsp_valid_o = r_refill_rsp_valid;
    assign bus.outstanding_o      = r_outstanding;
    assign bus.err_o              = r_err;
    assign bus.idle_o             = (r_state == IDLE) && (r_outstanding == '0) && !r_refill_rsp_valid;
    assign w_miss_wins            = bus.miss_valid_i && (r_ack_burst == BW'(ACK_BURST_MAX));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Arbitration, MSHR command generation and next state.
    always_comb begin
        w_state_next         = r_state;
        w_refill_grant       = 1'b0;
        w_miss_grant         = 1'b0;
        w_alloc              = 1'b0;
        bus.miss_ready_o     = 1'b0;
        bus.refill_ready_o   = 1'b0;
        bus.miss_rsp_valid_o = 1'b0;
        bus.miss_rsp_o       = 2'd0;
        bus.mshr_check_o     = 1'b0;
        bus.mshr_check_set_o = r_set;
        bus.mshr_check_tag_o = r_tag;
        bus.mshr_alloc_o     = 1'b0;
        bus.mshr_alloc_cs_o  = 1'b0;
        bus.mshr_ack_o       = 1'b0;
        bus.mshr_ack_cs_o    = 1'b0;
        case (r_state)
            IDLE: begin
                // Ready is held low during reset so nothing is granted.
                bus.refill_ready_o   = rst_ni && !w_miss_wins;
                bus.miss_ready_o     = rst_ni && !(bus.refill_valid_i && !w_miss_wins);
                bus.mshr_check_set_o = bus.miss_set_i;
                bus.mshr_check_tag_o = bus.miss_tag_i;
                w_refill_grant       = bus.refill_valid_i && bus.refill_ready_o;
                w_miss_grant         = bus.miss_valid_i && bus.miss_ready_o;
                if (w_refill_grant) begin
                    bus.mshr_ack_o    = 1'b1;
                    bus.mshr_ack_cs_o = 1'b1;
                end
                if (w_miss_grant) begin
                    bus.mshr_check_o = 1'b1;
                    w_state_next     = CHK;
                end
            end
            CHK: begin
                bus.miss_rsp_valid_o = 1'b1;
                if (bus.mshr_hit_i)             bus.miss_rsp_o = 2'd1;
                else if (bus.mshr_alloc_full_i) bus.miss_rsp_o = 2'd2;
                else begin
                    bus.miss_rsp_o      = 2'd0;
                    bus.mshr_alloc_o    = 1'b1;
                    bus.mshr_alloc_cs_o = 1'b1;
                    w_alloc             = 1'b1;
                end
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: burst limiter, captured request, outstanding count and error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack_burst        <= '0;
            r_set              <= '0;
            r_tag              <= '0;
            r_outstanding      <= '0;
            r_refill_rsp_valid <= 1'b0;
            r_err              <= 1'b0;
        end else begin
            r_refill_rsp_valid <= w_refill_grant;
            if (w_miss_grant || !bus.miss_valid_i)
                r_ack_burst <= '0;
            else if (w_refill_grant && (r_ack_burst != BW'(ACK_BURST_MAX)))
                r_ack_burst <= r_ack_burst + BW'(1);
            if (w_miss_grant) begin
                r_set <= bus.miss_set_i;
                r_tag <= bus.miss_tag_i;
            end
            // Alloc (CHK) and ack (IDLE) are mutually exclusive by construction.
            if (w_alloc) begin
                if (r_outstanding != '1) r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (w_refill_grant) begin
                if (r_outstanding == '0) r_err         <= 1'b1;
                else                     r_outstanding <= r_outstanding - CNT_W'(1);
            end
        end
    end

`ifdef HPDCACHE_MSHR_SCHED_STATS_EN
    // Saturating outcome counters, one step per CHK response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_alloc_o <= '0;
            stat_hit_o   <= '0;
            stat_full_o  <= '0;
        end else if (r_state == CHK) begin
            if (bus.miss_rsp_o == 2'd0 && stat_alloc_o != '1) stat_alloc_o <= stat_alloc_o + 32'd1;
            if (bus.miss_rsp_o == 2'd1 && stat_hit_o   != '1) stat_hit_o   <= stat_hit_o + 32'd1;
            if (bus.miss_rsp_o == 2'd2 && stat_full_o  != '1) stat_full_o  <= stat_full_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hpdcache_mshr_sched.sv
// Directed testbench for hpdcache_mshr_sched. Inputs change on the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_hpdcache_mshr_sched;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk_i = ~clk_i;

    hpdcache_mshr_sched_if #(.SET_W(7), .TAG_W(20), .MSET_W(2), .MWAY_W(2), .CNT_W(5)) bus ();

`ifdef HPDCACHE_MSHR_SCHED_STATS_EN
    logic [31:0] stat_alloc, stat_hit, stat_full;
`endif

    hpdcache_mshr_sched #(
        .SET_W(7), .TAG_W(20), .MSET_W(2), .MWAY_W(2), .CNT_W(5), .ACK_BURST_MAX(4)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
`ifdef HPDCACHE_MSHR_SCHED_STATS_EN
        ,
        .stat_alloc_o(stat_alloc),
        .stat_hit_o  (stat_hit),
        .stat_full_o (stat_full)
`endif
    );

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        bus.miss_valid_i = 1'b1; bus.refill_valid_i = 1'b1;
        bus.miss_set_i = '0; bus.miss_tag_i = '0; bus.refill_set_i = '0; bus.refill_way_i = '0;
        bus.mshr_hit_i = 1'b0; bus.mshr_alloc_full_i = 1'b0;
        cyc(); cyc(); #1;
        checks++; if (bus.miss_ready_o !== 1'b0) begin failures++; $display("FAIL rst_miss_ready got=%0h exp=0", bus.miss_ready_o); end
        checks++; if (bus.refill_ready_o !== 1'b0) begin failures++; $display("FAIL rst_refill_ready got=%0h exp=0", bus.refill_ready_o); end
        checks++; if (bus.mshr_ack_o !== 1'b0 || bus.mshr_check_o !== 1'b0) begin failures++; $display("FAIL rst_cmds got ack=%0h chk=%0h exp=0", bus.mshr_ack_o, bus.mshr_check_o); end
        checks++; if (bus.outstanding_o !== 5'd0 || bus.err_o !== 1'b0) begin failures++; $display("FAIL rst_counters got out=%0d err=%0h exp=0", bus.outstanding_o, bus.err_o); end
        cyc(); rst_ni = 1'b1; bus.miss_valid_i = 1'b0; bus.refill_valid_i = 1'b0; #1;
        checks++; if (bus.idle_o !== 1'b1) begin failures++; $display("FAIL post_rst_idle got=%0h exp=1", bus.idle_o); end
        checks++; if (bus.miss_ready_o !== 1'b1 || bus.refill_ready_o !== 1'b1) begin failures++; $display("FAIL post_rst_ready got miss=%0h refill=%0h exp=1", bus.miss_ready_o, bus.refill_ready_o); end
        $display("test_reset done");
    endtask

    task automatic test_alloc();
        cyc(); bus.miss_valid_i = 1'b1; bus.miss_set_i = 7'h12; bus.miss_tag_i = 20'hABC; #1;
        checks++; if (bus.mshr_check_o !== 1'b1) begin failures++; $display("FAIL alloc_check got=%0h exp=1", bus.mshr_check_o); end
        checks++; if (bus.mshr_check_set_o !== 7'h12 || bus.mshr_check_tag_o !== 20'hABC) begin failures++; $display("FAIL alloc_check_addr got set=%0h tag=%0h exp set=12 tag=abc", bus.mshr_check_set_o, bus.mshr_check_tag_o); end
        cyc(); bus.miss_valid_i = 1'b0; bus.miss_set_i = '0; bus.miss_tag_i = '0; bus.mshr_hit_i = 1'b0; bus.mshr_alloc_full_i = 1'b0; #1;
        checks++; if (bus.miss_rsp_valid_o !== 1'b1 || bus.miss_rsp_o !== 2'd0) begin failures++; $display("FAIL alloc_rsp got v=%0h rsp=%0d exp v=1 rsp=0", bus.miss_rsp_valid_o, bus.miss_rsp_o); end
        checks++; if (bus.mshr_alloc_o !== 1'b1 || bus.mshr_alloc_cs_o !== 1'b1) begin failures++; $display("FAIL alloc_cmd got alloc=%0h cs=%0h exp=1", bus.mshr_alloc_o, bus.mshr_alloc_cs_o); end
        checks++; if (bus.mshr_check_tag_o !== 20'hABC) begin failures++; $display("FAIL alloc_reg_tag got=%0h exp=abc", bus.mshr_check_tag_o); end
        checks++; if (bus.miss_ready_o !== 1'b0 || bus.refill_ready_o !== 1'b0 || bus.mshr_check_o !== 1'b0 || bus.mshr_ack_o !== 1'b0) begin failures++; $display("FAIL chk_quiet got mr=%0h rr=%0h chk=%0h ack=%0h exp=0", bus.miss_ready_o, bus.refill_ready_o, bus.mshr_check_o, bus.mshr_ack_o); end
        cyc(); #1;
        checks++; if (bus.outstanding_o !== 5'd1 || bus.miss_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL alloc_outstanding got out=%0d v=%0h exp out=1 v=0", bus.outstanding_o, bus.miss_rsp_valid_o); end
        $display("test_alloc done");
    endtask

    task automatic test_back_to_back();
        // Miss held valid: check, CHK(HIT), check, CHK(FULL).
        cyc(); bus.miss_valid_i = 1'b1; bus.miss_set_i = 7'h05; bus.miss_tag_i = 20'h11; #1;
        checks++; if (bus.mshr_check_o !== 1'b1) begin failures++; $display("FAIL b2b_check0 got=%0h exp=1", bus.mshr_check_o); end
        cyc(); bus.mshr_hit_i = 1'b1; #1;
        checks++; if (bus.mshr_check_o !== 1'b0 || bus.miss_rsp_valid_o !== 1'b1 || bus.miss_rsp_o !== 2'd1 || bus.mshr_alloc_o !== 1'b0) begin failures++; $display("FAIL b2b_hit got chk=%0h v=%0h rsp=%0d alloc=%0h exp chk=0 v=1 rsp=1 alloc=0", bus.mshr_check_o, bus.miss_rsp_valid_o, bus.miss_rsp_o, bus.mshr_alloc_o); end
        cyc(); bus.mshr_hit_i = 1'b0; #1;
        checks++; if (bus.mshr_check_o !== 1'b1 || bus.miss_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_check1 got chk=%0h v=%0h exp chk=1 v=0", bus.mshr_check_o, bus.miss_rsp_valid_o); end
        cyc(); bus.miss_valid_i = 1'b0; bus.mshr_alloc_full_i = 1'b1; #1;
        checks++; if (bus.miss_rsp_valid_o !== 1'b1 || bus.miss_rsp_o !== 2'd2 || bus.mshr_alloc_o !== 1'b0) begin failures++; $display("FAIL b2b_full got v=%0h rsp=%0d alloc=%0h exp v=1 rsp=2 alloc=0", bus.miss_rsp_valid_o, bus.miss_rsp_o, bus.mshr_alloc_o); end
        cyc(); bus.mshr_alloc_full_i = 1'b0; #1;
        checks++; if (bus.outstanding_o !== 5'd1) begin failures++; $display("FAIL b2b_outstanding got=%0d exp=1", bus.outstanding_o); end
        $display("test_back_to_back done");
    endtask

    task automatic test_arbitration();
        logic exp_ack [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_chk [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic exp_rrv [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        // Raise outstanding from 1 to 6 with five allocations.
        for (int i = 0; i < 5; i++) begin
            cyc(); bus.miss_valid_i = 1'b1;
            cyc(); bus.miss_valid_i = 1'b0;
        end
        cyc(); #1;
        checks++; if (bus.outstanding_o !== 5'd6) begin failures++; $display("FAIL arb_prefill got=%0d exp=6", bus.outstanding_o); end
        bus.mshr_hit_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(); bus.miss_valid_i = 1'b1; bus.refill_valid_i = 1'b1; bus.refill_set_i = 2'd3; bus.refill_way_i = 2'd1; #1;
            checks++; if (bus.mshr_ack_o !== exp_ack[i] || bus.mshr_check_o !== exp_chk[i] || bus.refill_rsp_valid_o !== exp_rrv[i]) begin failures++; $display("FAIL arb_cycle%0d got ack=%0h chk=%0h rrv=%0h exp ack=%0h chk=%0h rrv=%0h", i, bus.mshr_ack_o, bus.mshr_check_o, bus.refill_rsp_valid_o, exp_ack[i], exp_chk[i], exp_rrv[i]); end
            if (i == 0) begin
                checks++; if (bus.mshr_ack_set_o !== 2'd3 || bus.mshr_ack_way_o !== 2'd1 || bus.mshr_ack_cs_o !== 1'b1) begin failures++; $display("FAIL arb_ack_addr got set=%0d way=%0d cs=%0h exp set=3 way=1 cs=1", bus.mshr_ack_set_o, bus.mshr_ack_way_o, bus.mshr_ack_cs_o); end
            end
        end
        cyc(); bus.miss_valid_i = 1'b0; bus.refill_valid_i = 1'b0; bus.mshr_hit_i = 1'b0; #1;
        checks++; if (bus.outstanding_o !== 5'd0 || bus.err_o !== 1'b0) begin failures++; $display("FAIL arb_drain got out=%0d err=%0h exp out=0 err=0", bus.outstanding_o, bus.err_o); end
        $display("test_arbitration done");
    endtask

    task automatic test_ack_then_check();
        cyc(); bus.miss_valid_i = 1'b1;
        cyc(); bus.miss_valid_i = 1'b0;
        cyc(); bus.refill_valid_i = 1'b1; #1;
        checks++; if (bus.mshr_ack_o !== 1'b1 || bus.outstanding_o !== 5'd1) begin failures++; $display("FAIL atc_ack got ack=%0h out=%0d exp ack=1 out=1", bus.mshr_ack_o, bus.outstanding_o); end
        cyc(); bus.refill_valid_i = 1'b0; bus.miss_valid_i = 1'b1; #1;
        checks++; if (bus.mshr_check_o !== 1'b1 || bus.refill_rsp_valid_o !== 1'b1 || bus.mshr_ack_o !== 1'b0) begin failures++; $display("FAIL atc_overlap got chk=%0h rrv=%0h ack=%0h exp chk=1 rrv=1 ack=0", bus.mshr_check_o, bus.refill_rsp_valid_o, bus.mshr_ack_o); end
        checks++; if (bus.idle_o !== 1'b0) begin failures++; $display("FAIL atc_idle got=%0h exp=0", bus.idle_o); end
        cyc(); bus.miss_valid_i = 1'b0; #1;
        checks++; if (bus.mshr_alloc_o !== 1'b1 || bus.mshr_ack_o !== 1'b0 || bus.refill_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL atc_alloc got alloc=%0h ack=%0h rrv=%0h exp alloc=1 ack=0 rrv=0", bus.mshr_alloc_o, bus.mshr_ack_o, bus.refill_rsp_valid_o); end
        cyc(); #1;
        checks++; if (bus.outstanding_o !== 5'd1) begin failures++; $display("FAIL atc_outstanding got=%0d exp=1", bus.outstanding_o); end
        $display("test_ack_then_check done");
    endtask

    task automatic test_err();
        cyc(); bus.refill_valid_i = 1'b1;
        cyc(); #1;
        checks++; if (bus.outstanding_o !== 5'd0 || bus.err_o !== 1'b0) begin failures++; $display("FAIL err_pre got out=%0d err=%0h exp out=0 err=0", bus.outstanding_o, bus.err_o); end
        cyc(); bus.refill_valid_i = 1'b0; #1;
        checks++; if (bus.err_o !== 1'b1 || bus.outstanding_o !== 5'd0) begin failures++; $display("FAIL err_set got err=%0h out=%0d exp err=1 out=0", bus.err_o, bus.outstanding_o); end
        checks++; if (bus.idle_o !== 1'b0) begin failures++; $display("FAIL err_idle_rrv got=%0h exp=0", bus.idle_o); end
        cyc(); cyc(); cyc(); #1;
        checks++; if (bus.err_o !== 1'b1 || bus.idle_o !== 1'b1) begin failures++; $display("FAIL err_sticky got err=%0h idle=%0h exp err=1 idle=1", bus.err_o, bus.idle_o); end
        $display("test_err done");
    endtask

    task automatic test_reset_in_chk();
        cyc(); bus.miss_valid_i = 1'b1;
        cyc(); bus.miss_valid_i = 1'b0; #1;
        checks++; if (bus.miss_rsp_valid_o !== 1'b1) begin failures++; $display("FAIL rchk_in_chk got=%0h exp=1", bus.miss_rsp_valid_o); end
        rst_ni = 1'b0; #1;
        checks++; if (bus.miss_rsp_valid_o !== 1'b0 || bus.mshr_alloc_o !== 1'b0) begin failures++; $display("FAIL rchk_dropped got v=%0h alloc=%0h exp=0", bus.miss_rsp_valid_o, bus.mshr_alloc_o); end
        checks++; if (bus.err_o !== 1'b0 || bus.outstanding_o !== 5'd0 || bus.miss_ready_o !== 1'b0 || bus.refill_ready_o !== 1'b0) begin failures++; $display("FAIL rchk_state got err=%0h out=%0d mr=%0h rr=%0h exp=0", bus.err_o, bus.outstanding_o, bus.miss_ready_o, bus.refill_ready_o); end
        cyc(); rst_ni = 1'b1; #1;
        checks++; if (bus.idle_o !== 1'b1 || bus.miss_ready_o !== 1'b1 || bus.miss_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rchk_release got idle=%0h mr=%0h v=%0h exp idle=1 mr=1 v=0", bus.idle_o, bus.miss_ready_o, bus.miss_rsp_valid_o); end
        cyc(); #1;
        checks++; if (bus.miss_rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rchk_no_rsp got=%0h exp=0", bus.miss_rsp_valid_o); end
        $display("test_reset_in_chk done");
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_back_to_back();
        test_arbitration();
        test_ack_then_check();
        test_err();
        test_reset_in_chk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
